// File: rtl/spi_loader_pkg.sv
// Shared types and status-byte bit positions for the SPI program loader.
package spi_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; the output holds the last popped entry while empty.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_loader.sv
// Oversampled SPI slave that collects an address header plus data words and
// streams them through a FIFO to the NV-memory write port.
module spi_loader
  import spi_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int BYTE_SWAP   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              program_en,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic              pwe,
  input  logic              pready,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pdata,
  output logic              busy,
  output logic              overflow,
  output logic              trunc
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_s, mosi_s, ss_s, sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_q, ss_q;

  state_t state, state_nxt;
  logic abort, bit_rise, frame_start, shift_en, load_addr, word_done, set_trunc;
  logic [CNT_W-1:0]  bit_cnt;
  logic [MAX_W-2:0]  shreg;
  logic [MAX_W-1:0]  sr_next;
  logic [DATA_W-1:0] word_ord;
  logic [ADDR_W-1:0] ptr;
  logic              push_q;
  logic [ENT_W-1:0]  push_data;
  logic [7:0]        status_word;
  logic [7:0]        status_sr;
  logic              miso_q;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [ENT_W-1:0]  fifo_dout;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  // Edge pulses are registered so that mosi_q and ss_q line up with them.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      ss_rise   <= ss_s & ~ss_d;
      ss_fall   <= ~ss_s & ss_d;
      mosi_q    <= mosi_s;
      ss_q      <= ss_s;
    end
  end

  assign abort    = ss_fall | ~program_en;
  assign bit_rise = sclk_rise & ss_q & program_en;
  assign sr_next  = {shreg, mosi_q};

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ss_rise && program_en) state_nxt = ADDR;
      ADDR: begin
        if (abort)                                          state_nxt = IDLE;
        else if (bit_rise && bit_cnt == CNT_W'(ADDR_W - 1)) state_nxt = DATA;
      end
      DATA:    if (abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Leaving ADDR at any point, or DATA mid-word, loses bits and flags trunc.
  always_comb begin
    frame_start = 1'b0;
    shift_en    = 1'b0;
    load_addr   = 1'b0;
    word_done   = 1'b0;
    set_trunc   = 1'b0;
    case (state)
      IDLE: frame_start = ss_rise & program_en;
      ADDR: begin
        set_trunc = abort;
        shift_en  = bit_rise & ~abort;
        load_addr = shift_en & (bit_cnt == CNT_W'(ADDR_W - 1));
      end
      DATA: begin
        set_trunc = abort & (bit_cnt != '0);
        shift_en  = bit_rise & ~abort;
        word_done = shift_en & (bit_cnt == CNT_W'(DATA_W - 1));
      end
      default: ;
    endcase
  end

  generate
    if (BYTE_SWAP != 0) begin : g_swap
      always_comb begin
        word_ord = '0;
        for (int i = 0; i < DATA_W / 8; i++)
          word_ord[8*i +: 8] = sr_next[DATA_W - 8 - 8*i +: 8];
      end
    end else begin : g_noswap
      assign word_ord = sr_next[DATA_W-1:0];
    end
  endgenerate

  always_comb begin
    status_word           = '0;
    status_word[ST_OVF]   = overflow;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
  end

  // The status byte is presented before the first sclk rise, then advanced on each fall.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      status_sr <= '0;
      miso_q    <= 1'b0;
      overflow  <= 1'b0;
      trunc     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (frame_start) begin
        bit_cnt   <= '0;
        overflow  <= 1'b0;
        trunc     <= 1'b0;
        status_sr <= status_word << 1;
        miso_q    <= status_word[7];
      end
      if (shift_en) begin
        shreg   <= sr_next[MAX_W-2:0];
        bit_cnt <= (load_addr || word_done) ? '0 : bit_cnt + CNT_W'(1);
      end
      if (load_addr) ptr <= sr_next[ADDR_W-1:0];
      if (word_done) begin
        push_q    <= 1'b1;
        push_data <= {ptr, word_ord};
        ptr       <= ptr + ADDR_W'(1);
      end
      if (state != IDLE && state_nxt == IDLE) begin
        status_sr <= '0;
        miso_q    <= 1'b0;
      end else if (state != IDLE && sclk_fall) begin
        miso_q    <= status_sr[7];
        status_sr <= {status_sr[6:0], 1'b0};
      end
      if (set_trunc) trunc <= 1'b1;
      if (push_q && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .areset (areset),
    .push   (push_q),
    .pop    (fifo_pop),
    .din    (push_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign pwe            = ~fifo_empty;
  assign fifo_pop       = pwe & pready;
  assign {paddr, pdata} = fifo_dout;
  assign busy           = (state != IDLE) | ~fifo_empty;
  assign miso           = miso_q;

endmodule

// File: doc/spi_loader.md
Name: spi_loader

Overview:
- Parametrised successor to the SPI memory programmer; single-clock design in which the SPI pins are oversampled into clk.
- Accepts framed SPI writes carrying a start address followed by data words, and buffers the words in a FIFO.
- Drains the FIFO to the NV-memory write port with a valid/ready handshake.
- Reports status on miso and sticky error flags; sits between the board SPI header and the instruction/data memory mux while program=1.

Parameters:
DATA_W, 32, word width in bits; multiple of 8, range 8..64
ADDR_W, 16, word address width; also header length in bits
FIFO_DEPTH, 4, buffered words; power of 2, at least 2
BYTE_SWAP, 1, 1: first received byte lands in pdata[7:0]; 0: first received byte lands in pdata[DATA_W-1:DATA_W-8]
SYNC_STAGES, 2, synchroniser depth for sclk, mosi and ss; at least 2

Ports:
clk  in  1  system clock; must be at least 4x the sclk frequency
areset  in  1  asynchronous reset, active-low (0 = reset)
program  in  1  enables the loader; 0 aborts any frame in progress
sclk  in  1  SPI clock, mode 0, asynchronous to clk
mosi  in  1  SPI data in, MSB first
ss  in  1  frame select, active-high
miso  out  1  status serial out
pwe  out  1  write valid; high while FIFO is non-empty
pready  in  1  memory accepts the write when pwe=1 and pready=1
paddr  out  ADDR_W  write word address
pdata  out  DATA_W  write data
busy  out  1  state!=IDLE or FIFO non-empty
overflow  out  1  sticky: a completed word was dropped because the FIFO was full
trunc  out  1  sticky: frame ended with a partial word pending

Behaviour:
- Reset (areset=0, async): state=IDLE; FIFO empty; pwe=0, paddr=0, pdata=0, miso=0, busy=0, overflow=0, trunc=0; address pointer and bit counter cleared.
- Input capture: sclk, mosi and ss each pass through SYNC_STAGES flops. A rising sclk edge is detected when the synced value is 1 and was 0 on the previous clk; falling edge likewise.
- Data is sampled only on a detected rising edge while ss_s=1 and program=1.
- FSM states: IDLE, ADDR, DATA.
  - IDLE -> ADDR: on detected ss_s rising edge with program=1. Clears the bit counter, overflow and trunc, and loads the status shift register.
  - ADDR: shift ADDR_W bits MSB first. On the ADDR_W-th bit, load the address pointer, clear the bit counter, and go to DATA.
  - DATA: shift DATA_W bits. On the DATA_W-th bit, push {ptr, word} (word byte-ordered per BYTE_SWAP) into the FIFO and increment ptr modulo 2^ADDR_W (0xFFFF wraps to 0x0000 when ADDR_W=16). The bit counter restarts.
  - Any state -> IDLE: when ss_s falls or program=0.
    - Falling in DATA with bit counter != 0: partial word discarded, trunc=1.
    - Falling in ADDR: no write, trunc=1.
- Abort semantics: words already in the FIFO always drain, even after program=0.
- miso: shifts out STATUS = {overflow_prev, fifo_full, fifo_empty, 5'b0}, MSB first, updated on detected sclk falling edges for the first 8 bits of a frame, then 0. overflow_prev is the overflow value captured at frame start, before it is cleared.
- FIFO:
  - First-word-fall-through; pwe=!empty, and paddr/pdata are driven from the head entry.
  - Pop when pwe and pready are both 1.
  - Push while full with no pop in the same cycle: word dropped, overflow=1, ptr still increments.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - When empty, paddr/pdata hold their last values (0 after reset).
- Latency: the DATA_W-th sclk rise sampled by clk edge n gives pwe=1 at edge n+SYNC_STAGES+2 (synchroniser, edge detect, push).
- Host constraint: no inter-word gap needed while the FIFO is not full.
- Widths: bit counter is clog2(max(ADDR_W,DATA_W)+1) bits; pointer arithmetic is unsigned and truncated to ADDR_W.

Decomposition:
- Package spi_loader_pkg: state_t enum {IDLE, ADDR, DATA}; STATUS bit-position localparams (ST_OVF=7, ST_FULL=6, ST_EMPTY=5).
- Sub-module sync_fifo #(WIDTH, DEPTH): first-word-fall-through, async active-low reset, ports push/pop/din/dout/full/empty. Instantiated with WIDTH=ADDR_W+DATA_W.
- Synchroniser and edge detect stay inline.

Test Plan:
- Frame with address 0x0010, then words 0x11223344 and 0xAABBCCDD, pready=1, BYTE_SWAP=1 -> two writes: (0x0010, 0x44332211) then (0x0011, 0xDDCCBBAA). pwe exactly SYNC_STAGES+2 clk after the last bit of each word; busy falls after the second write.
- Address 0xFFFF, 2 words -> paddr 0xFFFF then 0x0000.
- pready=0, 6 words, FIFO_DEPTH=4 -> 4 words buffered, overflow=1. After pready=1: exactly 4 writes at addr A..A+3. Next frame: miso status byte is 0b1010_0000, and overflow clears.
- ss dropped after 40 bits of a frame with ADDR_W=16 (24 data bits) -> no write, trunc=1, state IDLE.
- program=0 mid-frame with 2 words buffered and pready toggling -> both words written, no further pushes; a frame while program=0 is ignored.
- areset asserted mid-frame with a non-empty FIFO -> all outputs 0 immediately (async). After release, a new frame loads correctly.
